// File: rtl/led_code_scheduler_if.sv
// Requester side of the LED blink-code scheduler.
// Requester i puts its code in req_code[i*CODE_W +: CODE_W].
interface led_code_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int CODE_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*CODE_W-1:0] req_code;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_code,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_code,
    output req_ready
  );
endinterface

// File: rtl/led_code_scheduler.sv
// Round-robin scheduler that plays blink codes on the shared status LED.
// One sequence is N lit pulses separated by dark gaps, then a quiet gap.
module led_code_scheduler #(
  parameter int NUM_REQ   = 3,
  parameter int CODE_W    = 4,
  parameter int TICK_DIV  = 48000,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int GAP_TICKS = 1000
) (
  input  logic                 CLK_48,
  input  logic                 RST_N,
  led_code_scheduler_if.slave  req,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic                 LED_A,
  output logic                 PMOD_A7,
  output logic                 PMOD_A8,
  output logic                 PMOD_A9,
  output logic                 PMOD_A10
);

  localparam int MAX_OO = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T  = (MAX_OO > GAP_TICKS) ? MAX_OO : GAP_TICKS;
  localparam int PW     = $clog2(TICK_DIV);
  localparam int TW     = $clog2(MAX_T + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

  logic [1:0]         state;
  logic [1:0]         last;
  logic [CODE_W-1:0]  remaining;
  logic [CODE_W-1:0]  rem_dec;
  logic [PW-1:0]      presc;
  logic [TW-1:0]      tcnt;
  logic [TW-1:0]      tlast;
  logic               tick;
  logic               phase_end;
  logic               led_on;
  logic               win_valid;
  logic [1:0]         win_idx;
  logic [CODE_W-1:0]  win_code;
  logic [NUM_REQ-1:0] ready;

  function automatic logic [1:0] rr_idx(
    input logic [1:0] base,
    input int         k
  );
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[1:0];
  endfunction

  // Search starts just past the last winner, so every requester gets a turn.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_valid && req.req_valid[rr_idx(last, k)]) begin
        win_valid = 1'b1;
        win_idx   = rr_idx(last, k);
      end
    end
  end

  assign win_code = req.req_code[int'(win_idx)*CODE_W +: CODE_W];

  always_comb begin
    ready = '0;
    if (state == S_IDLE && win_valid) ready[win_idx] = 1'b1;
  end

  assign req.req_ready = ready;

  always_comb begin
    unique case (1'b1)
      (state == S_ON):  tlast = ON_LAST;
      (state == S_OFF): tlast = OFF_LAST;
      default:          tlast = GAP_LAST;
    endcase
  end

  assign tick      = presc == PRE_LAST;
  assign phase_end = tick && (tcnt == tlast);
  assign rem_dec   = remaining - 1'b1;

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      last      <= 2'(NUM_REQ - 1);
      grant_id  <= '0;
      busy      <= 1'b0;
      led_on    <= 1'b0;
      remaining <= '0;
      presc     <= '0;
      tcnt      <= '0;
    end else begin
      if (state != S_IDLE) begin
        if (tick) begin
          presc <= '0;
          tcnt  <= phase_end ? '0 : tcnt + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
      unique case (state)
        S_IDLE: begin
          if (win_valid) begin
            last <= win_idx;
            if (win_code != '0) begin
              state     <= S_ON;
              remaining <= win_code;
              grant_id  <= win_idx;
              busy      <= 1'b1;
              led_on    <= 1'b1;
              presc     <= '0;
              tcnt      <= '0;
            end
          end
        end
        S_ON: begin
          if (phase_end) begin
            remaining <= rem_dec;
            led_on    <= 1'b0;
            state     <= (rem_dec != '0) ? S_OFF : S_GAP;
          end
        end
        S_OFF: begin
          if (phase_end) begin
            led_on <= 1'b1;
            state  <= S_ON;
          end
        end
        S_GAP: begin
          if (phase_end) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign LED_A    = ~led_on;
  assign PMOD_A7  = ~led_on;
  assign PMOD_A8  = ~busy;
  assign PMOD_A9  = ~grant_id[0];
  assign PMOD_A10 = ~grant_id[1];

endmodule

// File: tb/tb_led_code_scheduler.sv
// Bench for led_code_scheduler: directed scenarios plus random traffic,
// all checked against a per-cycle LED/busy schedule model.
module tb_led_code_scheduler;

  localparam int NR    = 3;
  localparam int CW    = 4;
  localparam int TD    = 4;
  localparam int ONT   = 2;
  localparam int OFFT  = 1;
  localparam int GAPT  = 3;
  localparam int ON_C  = ONT * TD;
  localparam int OFF_C = OFFT * TD;
  localparam int GAP_C = GAPT * TD;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  valid;
  logic [NR*CW-1:0] codes;
  logic [NR-1:0]  ready;
  logic           busy;
  logic [1:0]     grant_id;
  logic           LED_A;
  logic           P7, P8, P9, P10;

  int tests = 0;
  int fails = 0;

  led_code_scheduler_if #(.NUM_REQ(NR), .CODE_W(CW)) rif ();

  assign rif.req_valid = valid;
  assign rif.req_code  = codes;
  assign ready         = rif.req_ready;

  led_code_scheduler #(
    .NUM_REQ(NR), .CODE_W(CW), .TICK_DIV(TD),
    .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT)
  ) dut (
    .CLK_48(clk),
    .RST_N(rst_n),
    .req(rif),
    .busy(busy),
    .grant_id(grant_id),
    .LED_A(LED_A),
    .PMOD_A7(P7),
    .PMOD_A8(P8),
    .PMOD_A9(P9),
    .PMOD_A10(P10)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an idle arbiter plus a queue holding the lit/dark pattern
  // of the sequence being played, one entry per clock cycle.
  bit         mq[$];
  int         m_last = NR - 1;
  logic [1:0] mg = '0;

  always @(negedge clk) begin : model
    int            w;
    int            c;
    bit            l;
    logic          ebusy;
    logic          eled;
    logic [NR-1:0] er;
    if (!rst_n) begin
      mq.delete();
      m_last = NR - 1;
      mg     = '0;
    end else begin
      w = -1;
      er = '0;
      if (mq.size() != 0) begin
        l     = mq.pop_front();
        ebusy = 1'b1;
        eled  = ~l;
      end else begin
        ebusy = 1'b0;
        eled  = 1'b1;
        for (int k = 1; k <= NR; k++)
          if (w < 0 && valid[(m_last + k) % NR]) w = (m_last + k) % NR;
        if (w >= 0) er[w] = 1'b1;
      end
      chk("m_ready", ready, er);
      chk("m_busy", busy, ebusy);
      chk("m_led", LED_A, eled);
      chk("m_grant", grant_id, mg);
      chk("m_pmod", {P7, P8, P9, P10}, {eled, ~ebusy, ~mg[0], ~mg[1]});
      if (w >= 0) begin
        m_last = w;
        c = codes[w*CW +: CW];
        if (c != 0) begin
          mg = 2'(w);
          for (int p = 0; p < c; p++) begin
            repeat (ON_C) mq.push_back(1'b1);
            if (p < c - 1) repeat (OFF_C) mq.push_back(1'b0);
          end
          repeat (GAP_C) mq.push_back(1'b0);
        end
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input int code);
    codes[i*CW +: CW] = CW'(code);
    valid[i] = 1'b1;
  endtask

  // Returns just after the accepting edge (first cycle after it).
  task automatic wait_accept(input int i, output logic [NR-1:0] seen);
    bit done;
    done = 0;
    seen = '0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (ready[i]) begin
        seen = ready;
        @(posedge clk);
        #1 valid[i] = 1'b0;
        done = 1;
      end
    end
    chk("accept_seen", 32'(done), 1);
  endtask

  initial begin
    logic [NR-1:0] seen;
    logic [NR-1:0] acc;
    int order[4];
    int when[4];
    int na, cyc, pulses, bcnt, run, bad, r;
    logic prev;

    rst_n = 1'b1;
    valid = '0;
    codes = '0;

    // Reset takes effect between edges.
    #3 rst_n = 1'b0;
    #1;
    chk("t1_led", LED_A, 1);
    chk("t1_pmod", {P7, P8, P9, P10}, 4'b1111);
    chk("t1_busy", busy, 0);
    chk("t1_grant", grant_id, 0);
    chk("t1_ready", ready, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request, code 2.
    set_req(0, 2);
    wait_accept(0, seen);
    chk("t2_ready_pre", seen, 3'b001);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      chk("t2_led", LED_A, (c <= 8 || (c >= 13 && c <= 20)) ? 0 : 1);
      chk("t2_busy", busy, (c <= 32) ? 1 : 0);
      chk("t2_ready", ready, 0);
    end

    // Three requesters held valid with code 1.
    reset_dut();
    for (int i = 0; i < NR; i++) set_req(i, 1);
    na = 0;
    for (int n = 0; n < 200 && na < 4; n++) begin
      @(negedge clk);
      if (|ready) begin
        for (int i = 0; i < NR; i++) if (ready[i]) order[na] = i;
        when[na] = n;
        na++;
      end
    end
    @(posedge clk);
    #1 valid = '0;
    chk("t3_accepts", na, 4);
    chk("t3_g0", order[0], 0);
    chk("t3_g1", order[1], 1);
    chk("t3_g2", order[2], 2);
    chk("t3_g3", order[3], 0);
    chk("t3_gap01", when[1] - when[0], 21);
    chk("t3_gap23", when[3] - when[2], 21);
    repeat (25) @(posedge clk);

    // Zero code is consumed without playing anything.
    reset_dut();
    set_req(1, 0);
    wait_accept(1, seen);
    chk("t4_ready_pre", seen, 3'b010);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t4_busy", busy, 0);
      chk("t4_led", LED_A, 1);
      chk("t4_ready", ready, 0);
    end
    @(posedge clk);
    #1 set_req(0, 1);
    wait_accept(0, seen);
    chk("t4_ready0", seen, 3'b001);
    @(negedge clk);
    chk("t4_busy_on", busy, 1);
    chk("t4_grant", grant_id, 0);
    repeat (25) @(posedge clk);

    // Reset in the middle of a pulse, with requester 2 waiting.
    reset_dut();
    set_req(0, 3);
    set_req(2, 1);
    wait_accept(0, seen);
    chk("t5_ready_pre", seen, 3'b001);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_led", LED_A, 1);
    chk("t5_pmod", {P7, P8, P9, P10}, 4'b1111);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_accept(2, seen);
    chk("t5_ready2", seen, 3'b100);
    chk("t5_grant", grant_id, 2);
    chk("t5_a9", P9, 1);
    chk("t5_a10", P10, 0);
    repeat (25) @(posedge clk);

    // Maximum code.
    reset_dut();
    set_req(0, 15);
    wait_accept(0, seen);
    pulses = 0;
    bcnt   = 0;
    run    = 0;
    bad    = 0;
    prev   = 1'b1;
    for (int c = 0; c < 220; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (prev && !LED_A) pulses++;
      if (!LED_A) run++;
      else if (run != 0) begin
        if (run != ON_C) bad++;
        run = 0;
      end
      prev = LED_A;
    end
    chk("t6_pulses", pulses, 15);
    chk("t6_busy", bcnt, 188);
    chk("t6_badlen", bad, 0);

    // Random traffic.
    for (int it = 0; it < 4000; it++) begin
      if (it == 2000) reset_dut();
      @(negedge clk);
      acc = valid & ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          valid[i] = 1'b0;
        end else if (!valid[i]) begin
          if ($urandom_range(0, 15) == 0) begin
            r = $urandom_range(0, 9);
            set_req(i, (r == 0) ? 0 : (r == 1) ? 15 : $urandom_range(1, 3));
          end
        end else if ($urandom_range(0, 63) == 0) begin
          codes[i*CW +: CW] = CW'($urandom_range(0, 4));
        end
      end
    end
    valid = '0;
    repeat (250) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
